// File: rtl/aes_pkg.sv
// AES primitives shared by the iterative cipher: S-box table, GF(2^8) helpers,
// round-transform functions, state encoding and round-count constants.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int    NR_128     = 10;
    localparam int    NR_256     = 14;
    localparam byte_t RCON_START = 8'h01;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic byte_t sbox(input byte_t b);
        return SBOX[b];
    endfunction

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes are ordered top row first: a0 sits in bits [31:24].
    function automatic word_t mix_column(input word_t col);
        byte_t a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte n of a block lives at bits [127-8n -: 8]; n = row + 4*column.
    function automatic block_t shift_rows(input block_t b);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = b[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic block_t mix_columns(input block_t b);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = mix_column(b[127 - 32*c -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel S-box lookups on one 32-bit word; used for SubBytes columns
// and for SubWord in the key expansion.
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t a,
    output word_t y
);

    assign y = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/256 encryptor: one round per clock, round keys expanded on the fly.
// Defining AES_CIPHER_ABORT_EN adds an abort input that drops the block in flight.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
`ifdef AES_CIPHER_ABORT_EN
    input  logic                abort,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KEY_BITS-1:0] key,
    input  logic [127:0]        text_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        text_out,
    output logic                busy
);

    localparam int NR = (KEY_BITS == 256) ? NR_256 : NR_128;

    state_t              state, state_next;
    block_t              st;
    logic [KEY_BITS-1:0] kw, kw_next;
    byte_t               rcon;
    logic [3:0]          rnd;

    logic   abort_hit, accept, last_round, rot_step;
    word_t  last_word, sw_in, sw_out, sw_mix;
    word_t  nw0, nw1, nw2, nw3;
    block_t old4, new_words, round_key;
    block_t sb_out, sr_out, mc_out, round_out;

`ifdef AES_CIPHER_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
    assign busy       = (state == ROUND);
    assign accept     = in_valid && in_ready && !abort_hit;
    assign last_round = (rnd == 4'(NR));

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sub_word u_sub (
            .a (st[127 - 32*i -: 32]),
            .y (sb_out[127 - 32*i -: 32])
        );
    end

    assign sr_out    = shift_rows(sb_out);
    assign mc_out    = last_round ? sr_out : mix_columns(sr_out);
    assign round_out = mc_out ^ round_key;

    // The newest window word feeds SubWord; the oldest four words are XORed in.
    assign last_word = kw[31:0];
    assign old4      = kw[KEY_BITS-1 -: 128];
    assign sw_in     = rot_step ? {last_word[23:0], last_word[31:24]} : last_word;

    aes_sub_word u_key_sub (
        .a (sw_in),
        .y (sw_out)
    );

    assign sw_mix    = rot_step ? (sw_out ^ {rcon, 24'h000000}) : sw_out;
    assign nw0       = old4[127:96] ^ sw_mix;
    assign nw1       = old4[95:64]  ^ nw0;
    assign nw2       = old4[63:32]  ^ nw1;
    assign nw3       = old4[31:0]   ^ nw2;
    assign new_words = {nw0, nw1, nw2, nw3};

    if (KEY_BITS == 128) begin : g_k128
        assign rot_step  = 1'b1;
        assign round_key = new_words;
        assign kw_next   = new_words;
    end else if (KEY_BITS == 256) begin : g_k256
        // Round 1 takes words 4..7 of the loaded key as-is; later even rounds rotate.
        assign rot_step  = ~rnd[0];
        assign round_key = (rnd == 4'd1) ? kw[127:0] : new_words;
        assign kw_next   = (rnd == 4'd1) ? kw : {kw[127:0], new_words};
    end else begin : g_bad
        $error("aes_cipher_iter: KEY_BITS must be 128 or 256");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ROUND;
            ROUND:   if (last_round) state_next = DONE;
            DONE: begin
                if (accept) begin
                    state_next = ROUND;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort_hit) begin
            state_next = IDLE;
        end
    end

    // Accept wins over the DONE handshake so back-to-back blocks lose no cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= '0;
            kw        <= '0;
            rcon      <= '0;
            rnd       <= '0;
            text_out  <= '0;
            out_valid <= 1'b0;
        end else if (abort_hit) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            st        <= text_in ^ key[KEY_BITS-1 -: 128];
            kw        <= key;
            rcon      <= RCON_START;
            rnd       <= 4'd1;
            out_valid <= 1'b0;
        end else if (state == ROUND) begin
            st  <= round_out;
            kw  <= kw_next;
            rnd <= rnd + 4'd1;
            if (rot_step) begin
                rcon <= xtime(rcon);
            end
            if (last_round) begin
                text_out  <= round_out;
                out_valid <= 1'b1;
            end
        end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: one AES-128 and one AES-256 instance checked against
// known answers and a byte-level AES model. AES_CIPHER_ABORT_EN adds abort sequences.
module tb_aes_cipher_iter;

    typedef struct {
        int           d;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] key_w;
    logic [127:0] text_in;
    logic         out_ready;
    logic [1:0]   in_valid;
    wire  [1:0]   in_ready;
    wire  [1:0]   out_valid;
    wire  [1:0]   busy;
    wire  [127:0] text_out0;
    wire  [127:0] text_out1;
`ifdef AES_CIPHER_ABORT_EN
    logic         abort;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sbox_ref [256];

    always #5 clk = ~clk;

    aes_cipher_iter #(.KEY_BITS(128)) dut128 (
        .clk       (clk),
        .rst       (rst),
`ifdef AES_CIPHER_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .key       (key_w[255:128]),
        .text_in   (text_in),
        .out_valid (out_valid[0]),
        .out_ready (out_ready),
        .text_out  (text_out0),
        .busy      (busy[0])
    );

    aes_cipher_iter #(.KEY_BITS(256)) dut256 (
        .clk       (clk),
        .rst       (rst),
`ifdef AES_CIPHER_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .key       (key_w),
        .text_in   (text_in),
        .out_valid (out_valid[1]),
        .out_ready (out_ready),
        .text_out  (text_out1),
        .busy      (busy[1])
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return 8'((b << k) | (b >> (8 - k)));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
    endfunction

    // Full key schedule up front, then rounds on a 16-byte array.
    function automatic logic [127:0] aes_ref(input logic [255:0] k, input int nk, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        int           nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8];
        for (int rd = 0; rd <= nr; rd++) begin
            if (rd > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sbox_ref[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        t[r + 4*c] = s[r + 4*((c + r) % 4)];
                if (rd != nr) begin
                    for (int c = 0; c < 4; c++) begin
                        s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                        s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                        s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                        s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                    end
                end else begin
                    s = t;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] ct_of(input int d);
        return (d != 0) ? text_out1 : text_out0;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for in_ready, accepts on the next edge, then scrambles the inputs.
    task automatic applyStimulus(input int d, input logic [255:0] k, input logic [127:0] pt);
        int n;
        n = 0;
        key_w       = k;
        text_in     = pt;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && n < 40) begin
            tick();
            n++;
        end
        checkOutput("in_ready before accept", 128'(in_ready[d]), 128'd1);
        tick();
        in_valid[d] = 1'b0;
        key_w       = rand256();
        text_in     = rand256()[127:0];
    endtask

    task automatic wait_out(input int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput("out_valid arrives", 128'(out_valid[d]), 128'd1);
    endtask

    task automatic count_stale(input int d, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (out_valid[d]) seen++;
        end
        checkOutput("no out_valid after discard", 128'(seen), 128'd0);
    endtask

    task automatic run_block(input vec_t v);
        int lat;
        applyStimulus(v.d, v.key, v.pt);
        checkOutput("busy after accept", 128'(busy[v.d]), 128'd1);
        wait_out(v.d, lat);
        checkOutput("latency", 128'(lat), (v.d != 0) ? 128'd14 : 128'd10);
        checkOutput("ciphertext", ct_of(v.d), v.ct);
        tick();
        checkOutput("out_valid single cycle", 128'(out_valid[v.d]), 128'd0);
    endtask

    initial begin
        vec_t         vecs[$];
        vec_t         v;
        vec_t         va;
        vec_t         vb;
        int           lat;
        logic [255:0] k;
        logic [127:0] pt;

        rst       = 1'b1;
        in_valid  = 2'b00;
        out_ready = 1'b1;
        key_w     = '0;
        text_in   = '0;
`ifdef AES_CIPHER_ABORT_EN
        abort     = 1'b0;
`endif
        build_sbox();
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset in_ready", 128'(in_ready[d]), 128'd1);
            checkOutput("reset out_valid", 128'(out_valid[d]), 128'd0);
            checkOutput("reset busy", 128'(busy[d]), 128'd0);
            checkOutput("reset text_out", ct_of(d), 128'd0);
        end
        rst = 1'b0;
        tick();

        v.d = 0; v.key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        v.pt = 128'h00112233445566778899aabbccddeeff; v.ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vecs.push_back(v);
        v.d = 0; v.key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        v.pt = 128'h3243f6a8885a308d313198a2e0370734; v.ct = 128'h3925841d02dc09fbdc118597196a0b32;
        vecs.push_back(v);
        v.d = 1; v.key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        v.pt = 128'h00112233445566778899aabbccddeeff; v.ct = 128'h8ea2b7ca516745bfeafc49904b496089;
        vecs.push_back(v);
        for (int i = 0; i < 8; i++) begin
            v.d   = i % 2;
            v.key = rand256();
            v.pt  = rand256()[127:0];
            v.ct  = aes_ref(v.key, (v.d != 0) ? 8 : 4, v.pt);
            vecs.push_back(v);
        end

        $display("[TB] running %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) run_block(vecs[i]);

        $display("[TB] backpressure then simultaneous handshake and accept");
        va.d = 0; va.key = rand256(); va.pt = rand256()[127:0];
        va.ct = aes_ref(va.key, 4, va.pt);
        vb.d = 0; vb.key = rand256(); vb.pt = rand256()[127:0];
        vb.ct = aes_ref(vb.key, 4, vb.pt);
        out_ready = 1'b0;
        applyStimulus(0, va.key, va.pt);
        wait_out(0, lat);
        checkOutput("bp latency", 128'(lat), 128'd10);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp text_out held", text_out0, va.ct);
            checkOutput("bp out_valid held", 128'(out_valid[0]), 128'd1);
            checkOutput("bp in_ready low", 128'(in_ready[0]), 128'd0);
            tick();
        end
        out_ready = 1'b1;
        applyStimulus(0, vb.key, vb.pt);
        checkOutput("bp out_valid drops on accept", 128'(out_valid[0]), 128'd0);
        checkOutput("bp busy after accept", 128'(busy[0]), 128'd1);
        wait_out(0, lat);
        checkOutput("bp second latency", 128'(lat), 128'd10);
        checkOutput("bp second ciphertext", text_out0, vb.ct);
        tick();

        $display("[TB] reset in the middle of a block");
        k  = rand256();
        pt = rand256()[127:0];
        applyStimulus(0, k, pt);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid rst out_valid", 128'(out_valid[0]), 128'd0);
        checkOutput("mid rst text_out", text_out0, 128'd0);
        checkOutput("mid rst in_ready", 128'(in_ready[0]), 128'd1);
        checkOutput("mid rst busy", 128'(busy[0]), 128'd0);
        count_stale(0, 14);
        v.d = 0; v.key = rand256(); v.pt = rand256()[127:0];
        v.ct = aes_ref(v.key, 4, v.pt);
        run_block(v);
        v.d = 1; v.key = rand256(); v.pt = rand256()[127:0];
        v.ct = aes_ref(v.key, 8, v.pt);
        run_block(v);

`ifdef AES_CIPHER_ABORT_EN
        $display("[TB] abort during rounds and while holding a result");
        applyStimulus(0, rand256(), rand256()[127:0]);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort busy", 128'(busy[0]), 128'd0);
        checkOutput("abort in_ready", 128'(in_ready[0]), 128'd1);
        checkOutput("abort out_valid", 128'(out_valid[0]), 128'd0);
        count_stale(0, 14);
        out_ready = 1'b0;
        applyStimulus(1, rand256(), rand256()[127:0]);
        wait_out(1, lat);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort in DONE out_valid", 128'(out_valid[1]), 128'd0);
        checkOutput("abort in DONE in_ready", 128'(in_ready[1]), 128'd1);
        out_ready = 1'b1;
        v.d = 1; v.key = rand256(); v.pt = rand256()[127:0];
        v.ct = aes_ref(v.key, 8, v.pt);
        run_block(v);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
